// File: rtl/sgdmac_burst_engine.sv
// sgdmac_burst_engine
//   Execution stage of the scatter-gather DMAC. Pops {rw, addr, len} commands
//   from the command FIFO and splits each one into AXI INCR bursts of up to
//   MAX_BEATS 32-bit beats. Read commands move memory data into the data FIFO;
//   write commands drain the data FIFO to memory. Only one burst is ever in
//   flight on the shared AXI master port.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_*                    show-ahead command FIFO: empty flag, data, pop
//   done_o                   engine idle and no command pending
//   err_o                    sticky error: any non-OKAY rresp/bresp
//   ar*/r*                   AXI read address and read data channels
//   aw*/w*/b*                AXI write address, write data and response channels
//   dfifo_afull_i/wren/wdata read-path data FIFO push side
//   dfifo_empty_i/rden/rdata write-path data FIFO pop side (show-ahead)
//
// State table
//   state   | meaning
//   IDLE    | waiting for a command; pops and latches it
//   RD_ADDR | presenting AR for the current read burst
//   RD_DATA | accepting R beats into the data FIFO until rlast
//   WR_ADDR | presenting AW for the current write burst
//   WR_DATA | streaming W beats from the data FIFO until wlast
//   WR_RESP | waiting for the B response of the current write burst

module sgdmac_burst_engine #(
  parameter int unsigned MAX_BEATS = 16,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cmd_empty_i,
  input  logic [48:0] cmd_rdata_i,
  output logic        cmd_rden_o,

  output logic        done_o,
  output logic        err_o,

  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,

  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,

  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,

  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,

  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,

  input  logic        dfifo_afull_i,
  output logic        dfifo_wren_o,
  output logic [31:0] dfifo_wdata_o,

  input  logic        dfifo_empty_i,
  output logic        dfifo_rden_o,
  input  logic [31:0] dfifo_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [13:0] remaining_q;
  logic [3:0]  beat_cnt_q;
  logic        err_q;
  // Holds off command pops until the first clock after reset release, so
  // cmd_rden_o stays low for the whole time reset is asserted.
  logic        run_q;

  logic [4:0]  beats;
  logic [13:0] beats_ext;
  logic [3:0]  burst_len;
  logic        last_burst;
  logic        cmd_pop;
  logic        cmd_rw;
  logic [13:0] cmd_words;
  logic        ar_fire, r_fire, r_last_fire, aw_fire, w_fire, b_fire;
  logic        burst_done;
  logic        unused_ok;

  // Beats in the current burst: capped at MAX_BEATS, else whatever remains.
  assign beats      = (remaining_q >= 14'(MAX_BEATS)) ? 5'(MAX_BEATS) : remaining_q[4:0];
  assign beats_ext  = {9'd0, beats};
  assign burst_len  = 4'(beats - 5'd1);
  assign last_burst = (remaining_q == beats_ext);

  assign cmd_rw    = cmd_rdata_i[48];
  assign cmd_words = cmd_rdata_i[15:2];
  assign cmd_pop   = (state_q == IDLE) & ~cmd_empty_i & run_q;

  assign ar_fire     = (state_q == RD_ADDR) & arready_i;
  assign r_fire      = (state_q == RD_DATA) & rvalid_i & ~dfifo_afull_i;
  assign r_last_fire = r_fire & rlast_i;
  assign aw_fire     = (state_q == WR_ADDR) & awready_i;
  assign w_fire      = (state_q == WR_DATA) & ~dfifo_empty_i & wready_i;
  assign b_fire      = (state_q == WR_RESP) & bvalid_i;
  assign burst_done  = r_last_fire | b_fire;

  // IDs are not checked and the byte offsets of addr/len are discarded.
  assign unused_ok = ^{rid_i, bid_i, cmd_rdata_i[17:16], cmd_rdata_i[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A zero-word command is popped and dropped without AXI activity.
        if (cmd_pop && (cmd_words != 14'd0))
          state_d = cmd_rw ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: if (ar_fire) state_d = RD_DATA;
      RD_DATA: if (r_last_fire) state_d = last_burst ? IDLE : RD_ADDR;
      WR_ADDR: if (aw_fire) state_d = WR_DATA;
      WR_DATA: if (w_fire && (beat_cnt_q == 4'd0)) state_d = WR_RESP;
      WR_RESP: if (b_fire) state_d = last_burst ? IDLE : WR_ADDR;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_rden_o   = 1'b0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    dfifo_wren_o = 1'b0;
    awvalid_o    = 1'b0;
    wvalid_o     = 1'b0;
    wlast_o      = 1'b0;
    dfifo_rden_o = 1'b0;
    bready_o     = 1'b0;
    case (state_q)
      IDLE:    cmd_rden_o = ~cmd_empty_i & run_q;
      RD_ADDR: arvalid_o  = 1'b1;
      RD_DATA: begin
        rready_o     = ~dfifo_afull_i;
        dfifo_wren_o = rvalid_i & ~dfifo_afull_i;
      end
      WR_ADDR: awvalid_o = 1'b1;
      WR_DATA: begin
        wvalid_o     = ~dfifo_empty_i;
        wlast_o      = ~dfifo_empty_i & (beat_cnt_q == 4'd0);
        dfifo_rden_o = ~dfifo_empty_i & wready_i;
      end
      WR_RESP: bready_o = 1'b1;
      default: ;
    endcase
  end

  // Address / length / beat bookkeeping and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= 32'd0;
      remaining_q <= 14'd0;
      beat_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (cmd_pop) begin
        addr_q      <= {cmd_rdata_i[47:18], 2'b00};
        remaining_q <= cmd_words;
      end else if (burst_done) begin
        // Wraps modulo 2^32 by construction.
        addr_q      <= addr_q + {25'd0, beats, 2'b00};
        remaining_q <= remaining_q - beats_ext;
      end
      if (aw_fire)
        beat_cnt_q <= burst_len;
      else if (w_fire)
        beat_cnt_q <= beat_cnt_q - 4'd1;
      if ((r_fire && (rresp_i != 2'b00)) || (b_fire && (bresp_i != 2'b00)))
        err_q <= 1'b1;
    end
  end

  assign done_o        = (state_q == IDLE) & cmd_empty_i;
  assign err_o         = err_q;

  assign arid_o        = AXI_ID;
  assign araddr_o      = addr_q;
  assign arlen_o       = burst_len;
  assign arsize_o      = 3'b010;
  assign arburst_o     = 2'b01;

  assign awid_o        = AXI_ID;
  assign awaddr_o      = addr_q;
  assign awlen_o       = burst_len;
  assign awsize_o      = 3'b010;
  assign awburst_o     = 2'b01;

  assign wid_o         = AXI_ID;
  assign wdata_o       = dfifo_rdata_i;
  assign wstrb_o       = 4'hF;

  assign dfifo_wdata_o = rdata_i;

endmodule

// File: tb/tb_sgdmac_burst_engine.sv
// Testbench for sgdmac_burst_engine: AXI slave, command FIFO and data FIFO
// models plus a command-level reference that predicts bursts and data.
module tb_sgdmac_burst_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_empty_i;
  logic [48:0] cmd_rdata_i;
  logic        cmd_rden_o, done_o, err_o;
  logic [3:0]  arid_o, arlen_o, awid_o, awlen_o, wid_o, wstrb_o, rid_i, bid_i;
  logic [31:0] araddr_o, awaddr_o, wdata_o, rdata_i, dfifo_wdata_o, dfifo_rdata_i;
  logic [2:0]  arsize_o, awsize_o;
  logic [1:0]  arburst_o, awburst_o, rresp_i, bresp_i;
  logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
  logic        bvalid_i, bready_o;
  logic        dfifo_afull_i, dfifo_wren_o, dfifo_empty_i, dfifo_rden_o;

  always #5 clk = ~clk;

  sgdmac_burst_engine #(.MAX_BEATS(16), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_empty_i(cmd_empty_i), .cmd_rdata_i(cmd_rdata_i), .cmd_rden_o(cmd_rden_o),
    .done_o(done_o), .err_o(err_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .dfifo_afull_i(dfifo_afull_i), .dfifo_wren_o(dfifo_wren_o), .dfifo_wdata_o(dfifo_wdata_o),
    .dfifo_empty_i(dfifo_empty_i), .dfifo_rden_o(dfifo_rden_o), .dfifo_rdata_i(dfifo_rdata_i)
  );

  typedef struct packed {logic rw; logic [31:0] addr; logic [3:0] len;} burst_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {
    logic rw; logic [31:0] addr; logic [15:0] len;
    int n_bursts; logic [31:0] first_addr; int first_len;
    logic [31:0] last_addr; int last_len; int words;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  logic [48:0] cmd_q[$], ref_cmds[$];
  logic [31:0] wq[$], wsrc[$], rd_got[$];
  burst_t      blog[$];
  wr_t         wlog[$];
  int          pops;

  int          rbeats_left;
  logic [31:0] r_addr;
  bit          w_active;
  logic [31:0] w_addr;
  int          w_len, w_idx;
  bit          b_pending;
  int          b_count, b_err_idx;
  bit          ar_wait, aw_wait;
  burst_t      ar_hold, aw_hold;
  int p_ar = 100, p_r = 100, p_aw = 100, p_w = 100, p_b = 100, p_afull = 0, p_stall = 0;

  vec_t vecs[8];

  function automatic bit rnd(int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check and advance the
  // models 1 ns later, the DUT samples the same values at the next rising edge.
  task automatic step();
    @(negedge clk);
    cmd_empty_i   = (cmd_q.size() == 0);
    cmd_rdata_i   = (cmd_q.size() != 0) ? cmd_q[0] : '0;
    arready_i     = rnd(p_ar);
    rvalid_i      = (rbeats_left > 0) && rnd(p_r);
    rdata_i       = rd_word(r_addr);
    rlast_i       = (rbeats_left == 1);
    rresp_i       = 2'b00;
    rid_i         = 4'd0;
    awready_i     = rnd(p_aw);
    wready_i      = rnd(p_w);
    bvalid_i      = b_pending && rnd(p_b);
    bresp_i       = (b_count == b_err_idx) ? 2'b10 : 2'b00;
    bid_i         = 4'd0;
    dfifo_afull_i = rnd(p_afull);
    dfifo_empty_i = (wq.size() == 0) || rnd(p_stall);
    dfifo_rdata_i = (wq.size() != 0) ? wq[0] : '0;
    #1;
    check("rready", rready_o, (rbeats_left > 0) && !dfifo_afull_i);
    check("dfifo_wren", dfifo_wren_o, rvalid_i && rready_o);
    check("wvalid", wvalid_o, w_active && !dfifo_empty_i);
    check("dfifo_rden", dfifo_rden_o, wvalid_o && wready_i);
    check("bready", bready_o, b_pending);
    if (ar_wait) check("ar_hold", {arvalid_o, araddr_o, arlen_o}, {1'b1, ar_hold.addr, ar_hold.len});
    if (aw_wait) check("aw_hold", {awvalid_o, awaddr_o, awlen_o}, {1'b1, aw_hold.addr, aw_hold.len});
    ar_wait = arvalid_o && !arready_i;
    ar_hold = '{rw: 1'b0, addr: araddr_o, len: arlen_o};
    aw_wait = awvalid_o && !awready_i;
    aw_hold = '{rw: 1'b1, addr: awaddr_o, len: awlen_o};
    if (cmd_rden_o) begin
      check("cmd_pop_nonempty", cmd_q.size() != 0, 1);
      if (cmd_q.size() != 0) void'(cmd_q.pop_front());
      pops++;
    end
    if (rvalid_i && rready_o) begin
      check("dfifo_wdata", dfifo_wdata_o, rdata_i);
      rd_got.push_back(dfifo_wdata_o);
      r_addr = r_addr + 32'd4;
      rbeats_left--;
    end
    if (wvalid_o && wready_i) begin
      check("wlast", wlast_o, w_idx == w_len);
      wlog.push_back('{addr: w_addr + 32'(4 * w_idx), data: wdata_o});
      if (wq.size() != 0) void'(wq.pop_front());
      if (w_idx == w_len) begin
        w_active  = 1'b0;
        b_pending = 1'b1;
      end
      w_idx++;
    end
    if (bvalid_i && bready_o) begin
      b_pending = 1'b0;
      b_count++;
    end
    if (arvalid_o && arready_i) begin
      check("ar_one_outstanding", (rbeats_left > 0) || w_active || b_pending, 0);
      check("arsize_burst", {arsize_o, arburst_o}, {3'b010, 2'b01});
      blog.push_back('{rw: 1'b0, addr: araddr_o, len: arlen_o});
      r_addr      = araddr_o;
      rbeats_left = int'(arlen_o) + 1;
    end
    if (awvalid_o && awready_i) begin
      check("aw_one_outstanding", (rbeats_left > 0) || w_active || b_pending, 0);
      check("awsize_burst_strb", {awsize_o, awburst_o, wstrb_o}, {3'b010, 2'b01, 4'hF});
      blog.push_back('{rw: 1'b1, addr: awaddr_o, len: awlen_o});
      w_active = 1'b1;
      w_addr   = awaddr_o;
      w_len    = int'(awlen_o);
      w_idx    = 0;
    end
  endtask

  task automatic run_idle(int budget, string name);
    int n;
    n = 0;
    step();
    while (!(done_o && rbeats_left == 0 && !w_active && !b_pending && cmd_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, n >= budget, 0);
  endtask

  task automatic add_cmd(logic rw, logic [31:0] addr, logic [15:0] len);
    logic [31:0] d;
    cmd_q.push_back({rw, addr, len});
    ref_cmds.push_back({rw, addr, len});
    if (rw) for (int i = 0; i < int'(len[15:2]); i++) begin
      d = $urandom;
      wq.push_back(d);
      wsrc.push_back(d);
    end
  endtask

  task automatic clear_logs();
    blog.delete(); rd_got.delete(); wlog.delete(); ref_cmds.delete(); wsrc.delete();
    pops = 0;
  endtask

  // Reference: bursts, read stream and write stream derived per command.
  task automatic verify(string tag);
    burst_t exp_b[$];
    logic [31:0] exp_rd[$];
    wr_t exp_w[$];
    logic [31:0] a;
    int k, words, b;
    logic rw;
    k = 0;
    foreach (ref_cmds[i]) begin
      rw    = ref_cmds[i][48];
      a     = {ref_cmds[i][47:18], 2'b00};
      words = int'(ref_cmds[i][15:2]);
      for (int w = 0; w < words; w++) begin
        if (rw) begin
          exp_w.push_back('{addr: a + 32'(4 * w), data: wsrc[k]});
          k++;
        end else exp_rd.push_back(rd_word(a + 32'(4 * w)));
      end
      while (words > 0) begin
        b = (words > 16) ? 16 : words;
        exp_b.push_back('{rw: rw, addr: a, len: 4'(b - 1)});
        a = a + 32'(4 * b);
        words -= b;
      end
    end
    check({tag, "_pops"}, pops, ref_cmds.size());
    check({tag, "_nbursts"}, blog.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < blog.size(); i++)
      check($sformatf("%s_burst%0d", tag, i), blog[i], exp_b[i]);
    check({tag, "_nreads"}, rd_got.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_got[i], exp_rd[i]);
    check({tag, "_nwrites"}, wlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wlog[i], exp_w[i]);
  endtask

  initial begin
    cmd_empty_i = 1'b1; cmd_rdata_i = '0; arready_i = 0; rid_i = 0; rdata_i = 0; rresp_i = 0;
    rlast_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bid_i = 0; bresp_i = 0; bvalid_i = 0;
    dfifo_afull_i = 0; dfifo_empty_i = 1'b1; dfifo_rdata_i = 0;
    rbeats_left = 0; r_addr = 0; w_active = 0; w_addr = 0; w_len = 0; w_idx = 0;
    b_pending = 0; b_count = 0; b_err_idx = -1; ar_wait = 0; aw_wait = 0; pops = 0;
    ar_hold = '0; aw_hold = '0;

    vecs[0] = '{1'b0, 32'h0000_1000, 16'd64,  1, 32'h0000_1000, 15, 32'h0000_1000, 15, 16};
    vecs[1] = '{1'b1, 32'h0000_2000, 16'd72,  2, 32'h0000_2000, 15, 32'h0000_2040, 1,  18};
    vecs[2] = '{1'b0, 32'h0000_3000, 16'd0,   0, 32'h0,         0,  32'h0,         0,  0};
    vecs[3] = '{1'b1, 32'h0000_3000, 16'd3,   0, 32'h0,         0,  32'h0,         0,  0};
    vecs[4] = '{1'b0, 32'h0000_4003, 16'd11,  1, 32'h0000_4000, 1,  32'h0000_4000, 1,  2};
    vecs[5] = '{1'b1, 32'hFFFF_FFC0, 16'd80,  2, 32'hFFFF_FFC0, 15, 32'h0000_0000, 3,  20};
    vecs[6] = '{1'b0, 32'h0000_5000, 16'd68,  2, 32'h0000_5000, 15, 32'h0000_5040, 0,  17};
    vecs[7] = '{1'b1, 32'h0000_7000, 16'd256, 4, 32'h0000_7000, 15, 32'h0000_70C0, 15, 64};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_done_empty", done_o, 1);
    check("rst_outputs", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, dfifo_wren_o,
                          dfifo_rden_o, cmd_rden_o, err_o}, 9'd0);
    cmd_empty_i = 1'b0;
    #1;
    check("rst_done_nonempty", done_o, 0);
    check("rst_no_pop", cmd_rden_o, 0);
    cmd_empty_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Pop latency and AR payload stability under backpressure
    clear_logs();
    p_ar = 0;
    add_cmd(1'b0, 32'h0000_1000, 16'd64);
    step();
    check("lat_pop", cmd_rden_o, 1);
    check("lat_no_ar_at_pop", arvalid_o, 0);
    step();
    check("lat_ar_next", {cmd_rden_o, arvalid_o, araddr_o, arlen_o}, {2'b01, 32'h0000_1000, 4'd15});
    step(); step();
    p_ar = 100;
    run_idle(500, "lat");
    verify("lat");
    check("lat_done", done_o, 1);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      clear_logs();
      p_ar = 70; p_r = 70; p_aw = 70; p_w = 70; p_b = 70; p_afull = 20; p_stall = 20;
      add_cmd(vecs[v].rw, vecs[v].addr, vecs[v].len);
      run_idle(2000, $sformatf("vec%0d", v));
      verify($sformatf("vec%0d", v));
      check($sformatf("vec%0d_pops", v), pops, 1);
      check($sformatf("vec%0d_nb", v), blog.size(), vecs[v].n_bursts);
      check($sformatf("vec%0d_words", v), rd_got.size() + wlog.size(), vecs[v].words);
      if (blog.size() > 0) begin
        check($sformatf("vec%0d_first", v), {blog[0].rw, blog[0].addr, blog[0].len},
              {vecs[v].rw, vecs[v].first_addr, 4'(vecs[v].first_len)});
        check($sformatf("vec%0d_last", v), {blog[blog.size()-1].addr, blog[blog.size()-1].len},
              {vecs[v].last_addr, 4'(vecs[v].last_len)});
      end
      check($sformatf("vec%0d_done", v), done_o, 1);
    end

    // afull toggling with rvalid held high
    clear_logs();
    p_r = 100; p_afull = 50;
    add_cmd(1'b0, 32'h0000_6000, 16'd128);
    run_idle(2000, "afull");
    verify("afull");
    p_afull = 0;

    // Error response on the second write burst
    clear_logs();
    b_count = 0; b_err_idx = 1;
    add_cmd(1'b1, 32'h0000_8000, 16'd192);
    begin
      int n;
      n = 0;
      while (b_count < 1 && n < 1000) begin step(); n++; end
      check("berr_wait_b1", n >= 1000, 0);
    end
    step();
    check("err_after_b1", err_o, 0);
    run_idle(2000, "berr");
    verify("berr");
    check("err_set", err_o, 1);
    b_err_idx = -1;
    clear_logs();
    add_cmd(1'b0, 32'h0000_8800, 16'd32);
    run_idle(1000, "after_err");
    verify("after_err");
    check("err_sticky", err_o, 1);

    // Asynchronous reset in the middle of a read burst
    clear_logs();
    p_r = 50;
    add_cmd(1'b0, 32'h0000_9000, 16'd64);
    begin
      int n;
      n = 0;
      while (rd_got.size() < 3 && n < 500) begin step(); n++; end
      check("rst_mid_reach", n >= 500, 0);
    end
    check("rst_mid_in_data", rready_o | rvalid_i | (rbeats_left > 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, dfifo_wren_o,
                              dfifo_rden_o, cmd_rden_o, err_o}, 9'd0);
    check("rst_mid_done", done_o, 1);
    rbeats_left = 0; w_active = 0; b_pending = 0; ar_wait = 0; aw_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    p_r = 100;
    add_cmd(1'b0, 32'h0000_A000, 16'd40);
    run_idle(500, "post_rst");
    verify("post_rst");
    check("post_rst_nb", blog.size(), 1);

    // Randomized command streams
    for (int round = 0; round < 3; round++) begin
      clear_logs();
      p_ar = $urandom_range(100, 40); p_r = $urandom_range(100, 40);
      p_aw = $urandom_range(100, 40); p_w = $urandom_range(100, 40);
      p_b = $urandom_range(100, 40);
      p_afull = $urandom_range(40, 0); p_stall = $urandom_range(40, 0);
      for (int c = 0; c < 20; c++)
        add_cmd(1'($urandom_range(1, 0)), $urandom, 16'($urandom_range(200, 0)));
      run_idle(30000, $sformatf("rand%0d", round));
      verify($sformatf("rand%0d", round));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
